// File: rtl/nn_run_sequencer.sv
// -----------------------------------------------------------------------------
// nn_run_sequencer
//
// Host-side run controller for the MNIST NN accelerator.
//   * Buffers one image (N_WORDS x 32 bit) delivered by the host over a
//     valid/ready stream while holding the accelerator in reset.
//   * Releases the accelerator and serves image words combinationally,
//     addressed by the accelerator's own counter (acc_ctr).
//   * Waits for acc_ready (with a TIMEOUT guard), then streams the ten class
//     scores out one beat at a time and tracks the argmax class.
//
// Ports
//   clk          system clock
//   reset        synchronous active-low reset
//   start        one-cycle pulse, starts a new inference (IDLE/DONE/ERR only)
//   img_valid    host image word valid
//   img_data     host image word
//   img_ready    sequencer accepts image word (registered)
//   acc_reset    active-high reset to the accelerator (registered)
//   acc_ctr      accelerator counter1, used as image word address
//   acc_image    image word to the accelerator (combinational read)
//   acc_ready    accelerator finished (stop1 & stop2)
//   acc_results  result0..result9, result k at bits [32k+31:32k]
//   res_valid    score beat valid (registered)
//   res_ready    host accepts score beat
//   res_idx      class index of the current beat
//   res_data     signed score of the current beat
//   busy         high in LOAD, RUN and SCAN
//   done         high in DONE
//   error        high in ERR (accelerator never became ready)
//   class_idx    argmax class, valid while done
//   class_score  score of class_idx
// -----------------------------------------------------------------------------
module nn_run_sequencer #(
  parameter int N_WORDS = 784,
  parameter int RST_CYC = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         img_valid,
  input  logic [31:0]  img_data,
  output logic         img_ready,
  output logic         acc_reset,
  input  logic [31:0]  acc_ctr,
  output logic [31:0]  acc_image,
  input  logic         acc_ready,
  input  logic [319:0] acc_results,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [3:0]   res_idx,
  output logic [31:0]  res_data,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [3:0]   class_idx,
  output logic [31:0]  class_score
);

  localparam int AW = $clog2(N_WORDS);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0] LAST_WORD = AW'(N_WORDS - 1);
  localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT);
  localparam logic [TW-1:0] RST_CYC_T = TW'(RST_CYC);
  // First RUN cycle in which acc_ready is trusted: acc_reset has then been
  // low for two full cycles, so a ready left over from a previous run is gone.
  localparam logic [TW-1:0] ARM_T     = TW'(RST_CYC + 1);
  localparam logic [31:0]   DEPTH_32  = 32'(N_WORDS);
  localparam logic [3:0]    LAST_BEAT = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_SCAN = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [3:0]      beat_r;
  logic [TW-1:0]   timer_r;
  logic [31:0]     img_buf [N_WORDS];

  logic            img_accept_s;
  logic            last_word_s;
  logic [TW-1:0]   timer_next_s;
  logic            ready_armed_s;
  logic            res_hs_s;
  logic [3:0]      beat_next_s;

  // Select the 32-bit score of class k from the concatenated result bus.
  function automatic logic [31:0] result_word(input logic [319:0] results,
                                              input logic [3:0]   k);
    logic [31:0] word;
    word = 32'd0;
    for (int i = 0; i < 10; i++) begin
      if (k == 4'(i)) begin
        word = results[32*i +: 32];
      end
    end
    return word;
  endfunction

  // Signed "strictly greater" so that ties keep the earlier (lower) class.
  function automatic logic score_beats(input logic [31:0] cand,
                                       input logic [31:0] best);
    return $signed(cand) > $signed(best);
  endfunction

  // Decode handshakes and RUN-phase timing from the current registers.
  always_comb begin
    img_accept_s  = 1'b0;
    last_word_s   = 1'b0;
    timer_next_s  = timer_r + TW'(1);
    ready_armed_s = 1'b0;
    res_hs_s      = 1'b0;
    beat_next_s   = beat_r + 4'd1;
    if (state_r == S_LOAD) begin
      img_accept_s = img_valid & img_ready;
    end else begin
      img_accept_s = 1'b0;
    end
    last_word_s   = (wr_ptr_r == LAST_WORD);
    ready_armed_s = (timer_r >= ARM_T);
    if (state_r == S_SCAN) begin
      res_hs_s = res_valid & res_ready;
    end else begin
      res_hs_s = 1'b0;
    end
  end

  // Image buffer write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (reset && img_accept_s) begin
      img_buf[wr_ptr_r] <= img_data;
    end
  end

  // Image read port for the accelerator; zero outside RUN or past the image.
  always_comb begin
    acc_image = 32'd0;
    if ((state_r == S_RUN) && (acc_ctr < DEPTH_32)) begin
      acc_image = img_buf[acc_ctr[AW-1:0]];
    end else begin
      acc_image = 32'd0;
    end
  end

  // Main sequencer FSM with all handshake/status outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      img_ready   <= 1'b0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      acc_reset   <= 1'b1;
      class_idx   <= 4'd0;
      class_score <= 32'd0;
      res_idx     <= 4'd0;
      res_data    <= 32'd0;
      wr_ptr_r    <= '0;
      beat_r      <= 4'd0;
      timer_r     <= '0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_r     <= S_LOAD;
            wr_ptr_r    <= '0;
            img_ready   <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            class_idx   <= 4'd0;
            class_score <= 32'd0;
            acc_reset   <= 1'b1;
          end
        end

        S_LOAD: begin
          if (img_accept_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
            if (last_word_s) begin
              state_r   <= S_RUN;
              img_ready <= 1'b0;
              timer_r   <= '0;
            end
          end
        end

        S_RUN: begin
          // A qualified ready beats a simultaneous timeout.
          if (ready_armed_s && acc_ready) begin
            state_r   <= S_SCAN;
            beat_r    <= 4'd0;
            res_valid <= 1'b1;
            res_idx   <= 4'd0;
            res_data  <= result_word(acc_results, 4'd0);
            acc_reset <= 1'b0;
          end else if (timer_next_s == TIMEOUT_T) begin
            state_r   <= S_ERR;
            error     <= 1'b1;
            busy      <= 1'b0;
            acc_reset <= 1'b1;
          end else begin
            timer_r   <= timer_next_s;
            acc_reset <= (timer_next_s < RST_CYC_T);
          end
        end

        S_SCAN: begin
          // acc_reset stays low here so acc_results cannot change under us.
          if (res_hs_s) begin
            if ((beat_r == 4'd0) || score_beats(res_data, class_score)) begin
              class_idx   <= res_idx;
              class_score <= res_data;
            end
            if (beat_r == LAST_BEAT) begin
              state_r   <= S_DONE;
              res_valid <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              acc_reset <= 1'b1;
            end else begin
              beat_r   <= beat_next_s;
              res_idx  <= beat_next_s;
              res_data <= result_word(acc_results, beat_next_s);
            end
          end
        end

        default: begin
          // Unused encodings recover to a safe idle state.
          state_r   <= S_IDLE;
          img_ready <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          error     <= 1'b0;
          acc_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_run_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nn_run_sequencer
//
// Self-checking bench for nn_run_sequencer. The host image and the class
// scores are held in plain arrays; expected beats, argmax and acc_image reads
// are derived from those arrays directly.
// -----------------------------------------------------------------------------
module tb_nn_run_sequencer;

  localparam int N_WORDS = 784;
  localparam int RST_CYC = 4;
  localparam int TIMEOUT = 4096;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         img_valid;
  logic [31:0]  img_data;
  logic         img_ready;
  logic         acc_reset;
  logic [31:0]  acc_ctr;
  logic [31:0]  acc_image;
  logic         acc_ready;
  logic [319:0] acc_results;
  logic         res_valid;
  logic         res_ready;
  logic [3:0]   res_idx;
  logic [31:0]  res_data;
  logic         busy;
  logic         done;
  logic         error;
  logic [3:0]   class_idx;
  logic [31:0]  class_score;

  int checks = 0;
  int errors = 0;

  logic [31:0] img_mem [N_WORDS];
  int          exp_res [10];

  nn_run_sequencer #(.N_WORDS(N_WORDS), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .img_valid(img_valid), .img_data(img_data), .img_ready(img_ready),
    .acc_reset(acc_reset), .acc_ctr(acc_ctr), .acc_image(acc_image),
    .acc_ready(acc_ready), .acc_results(acc_results),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
    .res_data(res_data), .busy(busy), .done(done), .error(error),
    .class_idx(class_idx), .class_score(class_score)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_image(input bit ramp);
    for (int k = 0; k < N_WORDS; k++) begin
      img_mem[k] = ramp ? 32'(k) : $urandom();
    end
  endtask

  task automatic apply_results();
    for (int k = 0; k < 10; k++) begin
      acc_results[32*k +: 32] = 32'(exp_res[k]);
    end
  endtask

  // Reference argmax: first strictly greater score wins.
  task automatic model_argmax(output int bi, output int bs);
    bi = 0;
    bs = exp_res[0];
    for (int k = 1; k < 10; k++) begin
      if (exp_res[k] > bs) begin
        bi = k;
        bs = exp_res[k];
      end
    end
  endtask

  task automatic do_start(input bit with_valid);
    start     = 1'b1;
    img_valid = with_valid;
    img_data  = 32'hDEAD_BEEF;
    step();
    start     = 1'b0;
    img_valid = 1'b0;
    checks++; if (img_ready !== 1'b1) begin errors++; $display("FAIL start_img_ready: got %b want 1", img_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b want 1", busy); end
    checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL start_status: done=%b error=%b want 0 0", done, error); end
    checks++; if (class_idx !== 4'd0 || class_score !== 32'd0) begin errors++; $display("FAIL start_class_clear: idx=%0d score=%0d want 0 0", class_idx, class_score); end
    checks++; if (acc_reset !== 1'b1) begin errors++; $display("FAIL start_acc_reset: got %b want 1", acc_reset); end
  endtask

  task automatic load_words(input bit gaps);
    int  k;
    logic acc;
    k = 0;
    for (int cyc = 0; cyc < 4 * N_WORDS && k < N_WORDS; cyc++) begin
      img_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      img_data  = img_mem[k];
      acc       = img_valid & img_ready;
      step();
      if (acc) k++;
    end
    img_valid = 1'b0;
    checks++; if (k != N_WORDS) begin errors++; $display("FAIL load_count: got %0d words want %0d", k, N_WORDS); end
    checks++; if (img_ready !== 1'b0) begin errors++; $display("FAIL load_end_img_ready: got %b want 0", img_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_end_busy: got %b want 1", busy); end
  endtask

  // Accelerator model: raise ready 'delay' cycles after acc_reset falls,
  // reading random image words while it runs.
  task automatic wait_scan(input int delay);
    bit fell;
    int since;
    bit ok;
    logic [31:0] want;
    fell = 1'b0; since = 0; ok = 1'b0;
    for (int cyc = 0; cyc < TIMEOUT + 200; cyc++) begin
      if (res_valid === 1'b1) begin ok = 1'b1; break; end
      case ($urandom_range(0, 3))
        0: acc_ctr = $urandom_range(0, N_WORDS - 1);
        1: acc_ctr = $urandom_range(N_WORDS - 2, N_WORDS + 2);
        2: acc_ctr = $urandom();
        default: acc_ctr = $urandom_range(0, 3);
      endcase
      #1;
      want = (acc_ctr < N_WORDS) ? img_mem[acc_ctr] : 32'd0;
      checks++; if (acc_image !== want) begin errors++; $display("FAIL run_acc_image: ctr=%0d got %h want %h", acc_ctr, acc_image, want); end
      if (!fell && acc_reset === 1'b0) fell = 1'b1;
      if (fell) begin
        if (since >= delay) acc_ready = 1'b1;
        since++;
      end
      step();
    end
    acc_ready = 1'b0;
    acc_ctr   = 32'd0;
    checks++; if (!ok) begin errors++; $display("FAIL scan_wait: res_valid never rose, got 0 want 1"); end
  endtask

  task automatic collect(input int rr_mode);
    int n, bi, bs;
    n = 0;
    for (int cyc = 0; cyc < 400 && n < 10; cyc++) begin
      case (rr_mode)
        0: res_ready = 1'b1;
        1: res_ready = ((cyc % 4) == 0);
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
      if (res_valid === 1'b1) begin
        checks++; if (res_idx !== 4'(n)) begin errors++; $display("FAIL beat_idx: got %0d want %0d", res_idx, n); end
        checks++; if (res_data !== 32'(exp_res[n])) begin errors++; $display("FAIL beat_data[%0d]: got %0d want %0d", n, $signed(res_data), exp_res[n]); end
        if (res_ready) n++;
      end
      step();
    end
    model_argmax(bi, bs);
    checks++; if (n != 10) begin errors++; $display("FAIL beat_count: got %0d want 10", n); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL done_state: done=%b busy=%b want 1 0", done, busy); end
    checks++; if (acc_reset !== 1'b1) begin errors++; $display("FAIL done_acc_reset: got %b want 1", acc_reset); end
    checks++; if (class_idx !== 4'(bi)) begin errors++; $display("FAIL class_idx: got %0d want %0d", class_idx, bi); end
    checks++; if (class_score !== 32'(bs)) begin errors++; $display("FAIL class_score: got %0d want %0d", $signed(class_score), bs); end
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL extra_beat: res_valid got %b want 0", res_valid); end
    end
    acc_ctr = 32'd5;
    #1;
    checks++; if (acc_image !== 32'd0) begin errors++; $display("FAIL done_acc_image: got %h want 0", acc_image); end
    acc_ctr   = 32'd0;
    res_ready = 1'b0;
  endtask

  task automatic run_inference(input int rr_mode, input bit gaps, input int delay);
    apply_results();
    do_start($urandom_range(0, 1) == 1);
    load_words(gaps);
    wait_scan(delay);
    collect(rr_mode);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    checks++; if (img_ready !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL reset_handshake: img_ready=%b res_valid=%b want 0 0", img_ready, res_valid); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_status: busy=%b done=%b error=%b want 0 0 0", busy, done, error); end
    checks++; if (acc_reset !== 1'b1) begin errors++; $display("FAIL reset_acc_reset: got %b want 1", acc_reset); end
    checks++; if (class_idx !== 4'd0 || class_score !== 32'd0) begin errors++; $display("FAIL reset_class: idx=%0d score=%0d want 0 0", class_idx, class_score); end
  endtask

  task automatic test_basic();
    int addr [4];
    int want [4];
    addr = '{0, 1, 783, 784};
    want = '{0, 1, 783, 0};
    fill_image(1'b1);
    for (int k = 0; k < 10; k++) exp_res[k] = k * 100;
    exp_res[3] = 1000;
    apply_results();
    // start coincides with a valid word, which must not be taken.
    do_start(1'b1);
    load_words(1'b0);
    for (int i = 0; i < 4; i++) begin
      acc_ctr = 32'(addr[i]);
      #1;
      checks++; if (acc_image !== 32'(want[i])) begin errors++; $display("FAIL acc_image_fixed: ctr=%0d got %0d want %0d", addr[i], acc_image, want[i]); end
    end
    wait_scan(50);
    collect(0);
  endtask

  task automatic test_ties();
    fill_image(1'b0);
    for (int k = 0; k < 10; k++) exp_res[k] = -20;
    exp_res[2] = 500;
    exp_res[7] = 500;
    run_inference(2, 1'b1, 10);
    for (int k = 0; k < 10; k++) exp_res[k] = -5 - k;
    run_inference(2, 1'b0, 30);
  endtask

  task automatic test_backpressure();
    fill_image(1'b0);
    for (int k = 0; k < 10; k++) exp_res[k] = int'($urandom());
    run_inference(1, 1'b1, $urandom_range(0, 60));
  endtask

  task automatic test_stale_ready();
    int cnt;
    fill_image(1'b0);
    for (int k = 0; k < 10; k++) exp_res[k] = int'($urandom_range(0, 2000)) - 1000;
    apply_results();
    acc_ready = 1'b1;
    do_start(1'b0);
    load_words(1'b1);
    cnt = 0;
    while (acc_reset === 1'b1 && cnt < 100) begin
      cnt++;
      step();
    end
    checks++; if (cnt != RST_CYC) begin errors++; $display("FAIL rst_cyc_len: got %0d want %0d", cnt, RST_CYC); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL stale_ready_0: res_valid got %b want 0", res_valid); end
    step();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL stale_ready_1: res_valid got %b want 0", res_valid); end
    step();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL stale_ready_2: res_valid got %b want 1", res_valid); end
    acc_ready = 1'b0;
    collect(2);
  endtask

  task automatic test_timeout();
    fill_image(1'b0);
    acc_ready = 1'b0;
    do_start(1'b0);
    load_words(1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_early: error=%b busy=%b want 0 1", error, busy); end
    step();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b want 1", error); end
    checks++; if (acc_reset !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_outputs: acc_reset=%b busy=%b want 1 0", acc_reset, busy); end
    checks++; if (img_ready !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL timeout_handshake: img_ready=%b res_valid=%b want 0 0", img_ready, res_valid); end
    step();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_hold: got %b want 1", error); end
    for (int k = 0; k < 10; k++) exp_res[k] = int'($urandom());
    apply_results();
    do_start(1'b0);
    fill_image(1'b0);
    load_words(1'b1);
    wait_scan(7);
    collect(0);
  endtask

  task automatic test_reset_mid_scan();
    fill_image(1'b0);
    for (int k = 0; k < 10; k++) exp_res[k] = int'($urandom());
    apply_results();
    do_start(1'b0);
    load_words(1'b0);
    wait_scan(20);
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    res_ready = 1'b0;
    checks++; if (res_idx !== 4'd5 || res_valid !== 1'b1) begin errors++; $display("FAIL mid_scan_idx: idx=%0d valid=%b want 5 1", res_idx, res_valid); end
    test_reset();
    step();
    checks++; if (busy !== 1'b0 || acc_reset !== 1'b1) begin errors++; $display("FAIL post_reset_idle: busy=%b acc_reset=%b want 0 1", busy, acc_reset); end
    fill_image(1'b0);
    for (int k = 0; k < 10; k++) exp_res[k] = int'($urandom());
    run_inference(2, 1'b1, 40);
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    img_valid   = 1'b0;
    img_data    = 32'd0;
    acc_ctr     = 32'd0;
    acc_ready   = 1'b0;
    acc_results = '0;
    res_ready   = 1'b0;
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_stale_ready();
    test_timeout();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
